// File: rtl/merge_serializer_if.sv
// Handshake and data bundle for merge_serializer.
// With SORT_CHECK_EN defined the bundle also carries the sort_err flag.
interface merge_serializer_if #(
    parameter int WIDTH = 8,
    parameter int n     = 2
);
    localparam int IW = $clog2(2 * n);

    logic                   in_valid;
    logic                   in_ready;
    logic [2*n*WIDTH-1:0]   c;
    logic                   out_valid;
    logic                   out_ready;
    logic [WIDTH-1:0]       out_data;
    logic [IW-1:0]          out_idx;
    logic                   out_last;
    logic                   busy;
`ifdef SORT_CHECK_EN
    logic                   sort_err;

    modport master (
        output in_valid, c, out_ready,
        input  in_ready, out_valid, out_data, out_idx, out_last, busy, sort_err
    );
    modport slave (
        input  in_valid, c, out_ready,
        output in_ready, out_valid, out_data, out_idx, out_last, busy, sort_err
    );
`else
    modport master (
        output in_valid, c, out_ready,
        input  in_ready, out_valid, out_data, out_idx, out_last, busy
    );
    modport slave (
        input  in_valid, c, out_ready,
        output in_ready, out_valid, out_data, out_idx, out_last, busy
    );
`endif
endinterface

// File: rtl/merge_serializer.sv
// Captures a sorted 2*n-element vector and streams it out one element per transfer.
// Optional SORT_CHECK_EN adds sort_err, flagging an unsorted vector at capture.
module merge_serializer #(
    parameter int WIDTH = 8,
    parameter int n     = 2
) (
    input  logic              clk,
    input  logic              rst,
    merge_serializer_if.slave bus
);
    localparam int NE = 2 * n;
    localparam int IW = $clog2(NE);
    localparam logic [IW-1:0] LAST_IDX = IW'(NE - 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t         r_state, w_state_n;
    logic [WIDTH-1:0] r_vec [NE];
    logic [IW-1:0]  r_idx, w_idx_n;
    logic           w_valid, w_last, w_in_ready, w_in_xfer, w_out_xfer;

    assign w_valid    = (r_state == SEND);
    assign w_last     = w_valid && (r_idx == LAST_IDX);
    // Ready in SEND only as the last element leaves, so a new vector follows with no bubble.
    assign w_in_ready = !rst && ((r_state == IDLE) || (w_last && bus.out_ready));
    assign w_in_xfer  = bus.in_valid && w_in_ready;
    assign w_out_xfer = w_valid && bus.out_ready;

    always_comb begin
        w_state_n = r_state;
        w_idx_n   = r_idx;
        unique case (r_state)
            IDLE: begin
                if (w_in_xfer) begin
                    w_state_n = SEND;
                    w_idx_n   = '0;
                end
            end
            SEND: begin
                if (w_out_xfer) begin
                    if (w_last) begin
                        w_idx_n = '0;
                        if (!w_in_xfer) w_state_n = IDLE;
                    end else begin
                        w_idx_n = r_idx + 1'b1;
                    end
                end
            end
            default: w_state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_idx   <= '0;
            for (int unsigned k = 0; k < NE; k++) r_vec[k] <= '0;
        end else begin
            r_state <= w_state_n;
            r_idx   <= w_idx_n;
            if (w_in_xfer) begin
                for (int unsigned k = 0; k < NE; k++) r_vec[k] <= bus.c[k*WIDTH +: WIDTH];
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_valid;
    assign bus.out_data  = r_vec[r_idx];
    assign bus.out_idx   = r_idx;
    assign bus.out_last  = w_last;
    assign bus.busy      = w_valid;

`ifdef SORT_CHECK_EN
    logic r_sort_err;
    logic w_unsorted;

    always_comb begin
        w_unsorted = 1'b0;
        for (int unsigned k = 0; k + 1 < NE; k++) begin
            if (bus.c[k*WIDTH +: WIDTH] > bus.c[(k+1)*WIDTH +: WIDTH]) w_unsorted = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)            r_sort_err <= 1'b0;
        else if (w_in_xfer) r_sort_err <= w_unsorted;
    end

    assign bus.sort_err = r_sort_err;
`endif
endmodule
